tlb_op_ctrl: RTL

TLB maintenance sequencer sitting between the execute stage and the TLB address-translation block. Accepts one TLBSRCH/TLBRD/TLBWR/TLBFILL/INVTLB command at a time, drives the matching single-cycle enable into the TLB, waits out the TLB's one-cycle read latency, captures results, and returns a completion with a refetch request for mapping-changing ops. Also owns the TLBFILL replacement-index generator and stalls address translation while an op is in flight.

---
 rtl/tlb_op_ctrl.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/tlb_op_ctrl.sv
// TLB maintenance sequencer: issues one TLBSRCH/TLBRD/TLBWR/TLBFILL/INVTLB op at a time.
// Define TLB_LFSR_RAND_EN to draw the TLBFILL index from a 5-bit LFSR instead of a counter.
module tlb_op_ctrl #(
  parameter int unsigned TLBNUM = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        op_valid_i,
  output logic        op_ready_o,
  input  logic [2:0]  op_type_i,
  input  logic [4:0]  op_inv_op_i,
  input  logic [9:0]  op_inv_asid_i,
  input  logic [18:0] op_inv_vpn_i,
  output logic        tlbsrch_en_o,
  output logic        tlbwr_en_o,
  output logic        tlbfill_en_o,
  output logic        invtlb_en_o,
  output logic [4:0]  rand_index_o,
  output logic [4:0]  invtlb_op_o,
  output logic [9:0]  invtlb_asid_o,
  output logic [18:0] invtlb_vpn_o,
  input  logic        search_tlb_found_i,
  input  logic [4:0]  search_tlb_index_i,
  input  logic [31:0] tlbehi_in_rd_i,
  input  logic [31:0] tlbelo0_in_rd_i,
  input  logic [31:0] tlbelo1_in_rd_i,
  input  logic [31:0] tlbidx_in_rd_i,
  input  logic [9:0]  asid_in_rd_i,
  output logic        trans_stall_o,
  output logic        done_valid_o,
  input  logic        done_ready_i,
  output logic        done_found_o,
  output logic [4:0]  done_index_o,
  output logic [31:0] done_ehi_o,
  output logic [31:0] done_elo0_o,
  output logic [31:0] done_elo1_o,
  output logic [31:0] done_idx_o,
  output logic [9:0]  done_asid_o,
  output logic        done_refetch_o,
  output logic        done_err_o
);

  localparam logic [2:0] OP_SRCH = 3'd0;
  localparam logic [2:0] OP_RD   = 3'd1;
  localparam logic [2:0] OP_WR   = 3'd2;
  localparam logic [2:0] OP_FILL = 3'd3;
  localparam logic [2:0] OP_INV  = 3'd4;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_e;

  state_e      state_q, state_d;
  logic        op_ready_q, op_ready_d;
  logic        srch_en_q, srch_en_d, wr_en_q, wr_en_d;
  logic        fill_en_q, fill_en_d, inv_en_q, inv_en_d;
  logic        stall_q, stall_d, dvalid_q, dvalid_d;
  logic [2:0]  op_type_q, op_type_d;
  logic [4:0]  rand_idx_q, rand_idx_d, rnd_q, rnd_d;
  logic [4:0]  inv_op_q, inv_op_d;
  logic [9:0]  inv_asid_q, inv_asid_d;
  logic [18:0] inv_vpn_q, inv_vpn_d;
  logic        found_q, found_d, refetch_q, refetch_d, err_q, err_d;
  logic [4:0]  index_q, index_d;
  logic [31:0] ehi_q, ehi_d, elo0_q, elo0_d, elo1_q, elo1_d, idx_q, idx_d;
  logic [9:0]  asid_q, asid_d;
  logic        in_legal_c, q_legal_c;

  // Illegal: reserved op_type or an INVTLB sub-op beyond 6
  assign in_legal_c = (op_type_i <= OP_INV) && !((op_type_i == OP_INV) && (op_inv_op_i > 5'd6));
  assign q_legal_c  = (op_type_q <= OP_INV) && !((op_type_q == OP_INV) && (inv_op_q > 5'd6));

`ifdef TLB_LFSR_RAND_EN
  // Fibonacci LFSR x^5+x^3+1; never reaches zero from a nonzero seed
  assign rnd_d = {rnd_q[3:0], rnd_q[4] ^ rnd_q[2]};
`else
  localparam logic [4:0] IDX_LAST = 5'(TLBNUM - 1);
  assign rnd_d = (rnd_q == IDX_LAST) ? 5'd0 : rnd_q + 5'd1;
`endif

  always_comb begin
    state_d    = state_q;
    srch_en_d  = 1'b0;
    wr_en_d    = 1'b0;
    fill_en_d  = 1'b0;
    inv_en_d   = 1'b0;
    op_type_d  = op_type_q;
    rand_idx_d = rand_idx_q;
    inv_op_d   = inv_op_q;
    inv_asid_d = inv_asid_q;
    inv_vpn_d  = inv_vpn_q;
    found_d    = found_q;
    index_d    = index_q;
    ehi_d      = ehi_q;
    elo0_d     = elo0_q;
    elo1_d     = elo1_q;
    idx_d      = idx_q;
    asid_d     = asid_q;
    refetch_d  = refetch_q;
    err_d      = err_q;
    unique case (state_q)
      S_IDLE: begin
        if (op_valid_i && op_ready_q) begin
          state_d    = S_ISSUE;
          op_type_d  = op_type_i;
          rand_idx_d = rnd_q;
          inv_op_d   = op_inv_op_i;
          inv_asid_d = op_inv_asid_i;
          inv_vpn_d  = op_inv_vpn_i;
          srch_en_d  = in_legal_c && (op_type_i == OP_SRCH);
          wr_en_d    = in_legal_c && (op_type_i == OP_WR);
          fill_en_d  = in_legal_c && (op_type_i == OP_FILL);
          inv_en_d   = in_legal_c && (op_type_i == OP_INV);
        end
      end
      S_ISSUE: state_d = S_WAIT;
      S_WAIT: begin
        // TLB read latency has elapsed; fields not owned by this op read as zero
        state_d   = S_DONE;
        found_d   = (op_type_q == OP_SRCH) && search_tlb_found_i;
        index_d   = (op_type_q == OP_SRCH) ? search_tlb_index_i : 5'd0;
        ehi_d     = (op_type_q == OP_RD) ? tlbehi_in_rd_i : 32'd0;
        elo0_d    = (op_type_q == OP_RD) ? tlbelo0_in_rd_i : 32'd0;
        elo1_d    = (op_type_q == OP_RD) ? tlbelo1_in_rd_i : 32'd0;
        idx_d     = (op_type_q == OP_RD) ? tlbidx_in_rd_i : 32'd0;
        asid_d    = (op_type_q == OP_RD) ? asid_in_rd_i : 10'd0;
        refetch_d = q_legal_c && (op_type_q inside {OP_WR, OP_FILL, OP_INV});
        err_d     = !q_legal_c;
      end
      S_DONE: if (done_ready_i) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    op_ready_d = (state_d == S_IDLE);
    stall_d    = (state_d == S_ISSUE) || (state_d == S_WAIT);
    dvalid_d   = (state_d == S_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      op_ready_q <= 1'b0;
      srch_en_q  <= 1'b0;
      wr_en_q    <= 1'b0;
      fill_en_q  <= 1'b0;
      inv_en_q   <= 1'b0;
      stall_q    <= 1'b0;
      dvalid_q   <= 1'b0;
      op_type_q  <= 3'd0;
      rand_idx_q <= 5'd0;
`ifdef TLB_LFSR_RAND_EN
      rnd_q      <= 5'b00001;
`else
      rnd_q      <= 5'd0;
`endif
      inv_op_q   <= 5'd0;
      inv_asid_q <= 10'd0;
      inv_vpn_q  <= 19'd0;
      found_q    <= 1'b0;
      index_q    <= 5'd0;
      ehi_q      <= 32'd0;
      elo0_q     <= 32'd0;
      elo1_q     <= 32'd0;
      idx_q      <= 32'd0;
      asid_q     <= 10'd0;
      refetch_q  <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_ready_q <= op_ready_d;
      srch_en_q  <= srch_en_d;
      wr_en_q    <= wr_en_d;
      fill_en_q  <= fill_en_d;
      inv_en_q   <= inv_en_d;
      stall_q    <= stall_d;
      dvalid_q   <= dvalid_d;
      op_type_q  <= op_type_d;
      rand_idx_q <= rand_idx_d;
      rnd_q      <= rnd_d;
      inv_op_q   <= inv_op_d;
      inv_asid_q <= inv_asid_d;
      inv_vpn_q  <= inv_vpn_d;
      found_q    <= found_d;
      index_q    <= index_d;
      ehi_q      <= ehi_d;
      elo0_q     <= elo0_d;
      elo1_q     <= elo1_d;
      idx_q      <= idx_d;
      asid_q     <= asid_d;
      refetch_q  <= refetch_d;
      err_q      <= err_d;
    end
  end

  assign op_ready_o     = op_ready_q;
  assign tlbsrch_en_o   = srch_en_q;
  assign tlbwr_en_o     = wr_en_q;
  assign tlbfill_en_o   = fill_en_q;
  assign invtlb_en_o    = inv_en_q;
  assign rand_index_o   = rand_idx_q;
  assign invtlb_op_o    = inv_op_q;
  assign invtlb_asid_o  = inv_asid_q;
  assign invtlb_vpn_o   = inv_vpn_q;
  assign trans_stall_o  = stall_q;
  assign done_valid_o   = dvalid_q;
  assign done_found_o   = found_q;
  assign done_index_o   = index_q;
  assign done_ehi_o     = ehi_q;
  assign done_elo0_o    = elo0_q;
  assign done_elo1_o    = elo1_q;
  assign done_idx_o     = idx_q;
  assign done_asid_o    = asid_q;
  assign done_refetch_o = refetch_q;
  assign done_err_o     = err_q;

endmodule
